// File: rtl/greenhouse_pkg.sv
// Shared types and register-map constants for the greenhouse actuator controller.
package greenhouse_pkg;

    typedef enum logic [1:0] {
        IDLE,
        IRRIGATE,
        VENTILATE,
        DONE
    } gh_state_t;

    localparam logic [3:0] CTRL_OFF = 4'h0;
    localparam logic [3:0] IRR_OFF  = 4'h4;
    localparam logic [3:0] VENT_OFF = 4'h8;
    localparam logic [3:0] STAT_OFF = 4'hC;

    localparam int unsigned CTRL_START_IRR  = 0;
    localparam int unsigned CTRL_START_VENT = 1;
    localparam int unsigned CTRL_ABORT      = 2;

    localparam int unsigned STAT_BUSY     = 0;
    localparam int unsigned STAT_IRR      = 1;
    localparam int unsigned STAT_VENT     = 2;
    localparam int unsigned STAT_DONE     = 3;
    localparam int unsigned STAT_IRQ      = 4;
    localparam int unsigned STAT_CLR_DONE = 0;

endpackage

// File: rtl/gh_phase_timer.sv
// Down-counting phase timer: load takes priority, counts down while enabled, holds at zero.
module gh_phase_timer #(
    parameter int unsigned DUR_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [DUR_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [DUR_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - DUR_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/greenhouse_io_ctrl.sv
// Memory-mapped irrigation/ventilation sequencer on the CPU data bus.
// Optional GREENHOUSE_IRQ_EN adds a completion interrupt output (STATUS bit4).
module greenhouse_io_ctrl
    import greenhouse_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0200,
    parameter int unsigned DUR_W     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        sel,
    output logic        irrigation_active,
    output logic        ventilation_active,
    output logic        peripheral_done
`ifdef GREENHOUSE_IRQ_EN
    ,
    output logic        irq
`endif
);

    gh_state_t        state, next_state;
    logic [DUR_W-1:0] irr_dur, vent_dur, tmr_val;
    logic [3:0]       off;
    logic             wr, ctrl_wr, start, abort, stat_clr;
    logic             busy, vent_req, tmr_load, tmr_zero, done_evt;
    logic [31:0]      status;
    logic             unused_bits;

    assign sel      = (DataAdr[31:4] == BASE_ADDR[31:4]);
    assign off      = {DataAdr[3:2], 2'b00};
    assign wr       = MemWrite && sel;
    assign ctrl_wr  = wr && (off == CTRL_OFF);
    assign abort    = ctrl_wr && WriteData[CTRL_ABORT];
    assign start    = ctrl_wr && !WriteData[CTRL_ABORT] &&
                      (WriteData[CTRL_START_IRR] || WriteData[CTRL_START_VENT]);
    assign stat_clr = wr && (off == STAT_OFF) && WriteData[STAT_CLR_DONE];
    assign busy     = (state == IRRIGATE) || (state == VENTILATE);

    assign unused_bits = ^{DataAdr[1:0], WriteData[31:DUR_W]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irr_dur  <= '0;
            vent_dur <= '0;
        end else begin
            if (wr && (off == IRR_OFF))  irr_dur  <= WriteData[DUR_W-1:0];
            if (wr && (off == VENT_OFF)) vent_dur <= WriteData[DUR_W-1:0];
        end
    end

    gh_phase_timer #(.DUR_W(DUR_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (busy),
        .zero     (tmr_zero)
    );

    // Zero-length phases are skipped at decision time so they never produce an active pulse.
    always_comb begin
        next_state = state;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    if (WriteData[CTRL_START_IRR] && (irr_dur != '0)) begin
                        next_state = IRRIGATE;
                        tmr_load   = 1'b1;
                        tmr_val    = irr_dur - DUR_W'(1);
                    end else if (WriteData[CTRL_START_VENT] && (vent_dur != '0)) begin
                        next_state = VENTILATE;
                        tmr_load   = 1'b1;
                        tmr_val    = vent_dur - DUR_W'(1);
                    end else begin
                        next_state = DONE;
                    end
                end else if ((state == DONE) && stat_clr) begin
                    next_state = IDLE;
                end
            end
            IRRIGATE: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (tmr_zero) begin
                    if (vent_req && (vent_dur != '0)) begin
                        next_state = VENTILATE;
                        tmr_load   = 1'b1;
                        tmr_val    = vent_dur - DUR_W'(1);
                    end else begin
                        next_state = DONE;
                    end
                end
            end
            VENTILATE: begin
                if (abort) next_state = IDLE;
                else if (tmr_zero) next_state = DONE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign done_evt = (next_state == DONE) && ((state != DONE) || start);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            vent_req           <= 1'b0;
            irrigation_active  <= 1'b0;
            ventilation_active <= 1'b0;
            peripheral_done    <= 1'b0;
        end else begin
            state              <= next_state;
            if (start && !busy) vent_req <= WriteData[CTRL_START_VENT];
            irrigation_active  <= (next_state == IRRIGATE);
            ventilation_active <= (next_state == VENTILATE);
            peripheral_done    <= (next_state == DONE);
        end
    end

`ifdef GREENHOUSE_IRQ_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        irq <= 1'b0;
        else if (done_evt) irq <= 1'b1;
        else if (stat_clr) irq <= 1'b0;
    end
`endif

    always_comb begin
        status            = '0;
        status[STAT_BUSY] = busy;
        status[STAT_IRR]  = irrigation_active;
        status[STAT_VENT] = ventilation_active;
        status[STAT_DONE] = peripheral_done;
`ifdef GREENHOUSE_IRQ_EN
        status[STAT_IRQ]  = irq;
`else
        status[STAT_IRQ]  = done_evt & 1'b0;
`endif
    end

    always_comb begin
        ReadData = '0;
        if (sel) begin
            case (off)
                IRR_OFF:  ReadData = {{(32-DUR_W){1'b0}}, irr_dur};
                VENT_OFF: ReadData = {{(32-DUR_W){1'b0}}, vent_dur};
                STAT_OFF: ReadData = status;
                default:  ReadData = '0;
            endcase
        end
    end

endmodule
